// File: rtl/dpram_pkg.sv
// Shared constants and helpers for the configurable dual-port RAM / FIFO primitive.
package dpram_pkg;

  // Values of the fifo_mode configuration bit
  localparam logic MODE_RAM  = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  // Occupancy counter must represent 0..DEPTH, so one bit wider than an address
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/dpram_sdp_core.sv
// Simple dual-port storage: one write port, one registered read port with
// optional write-first bypass. The array itself has no reset.
//   clk, rst_n          : clock, async active-low reset (read register only)
//   we, waddr, wdata    : write port
//   re, raddr           : read port, rdata valid after the edge sampling re
//   bypass_en           : enables write-first forwarding on address collision
//   rdata               : registered read data, holds when re=0
module dpram_sdp_core #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  bypass_en,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  collide;

  // Storage array write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign collide = bypass_en && we && (waddr == raddr);

  // Registered read with write-first forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= collide ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/dpram_fifo_cfg.sv
// Parametrised dual-port RAM primitive that can be configured as a synchronous FIFO.
//   clk, rst_n        : clock, async active-low reset
//   fifo_mode         : 0 = RAM, 1 = FIFO (quasi-static config bit)
//   waddr, raddr      : external addresses (RAM mode only)
//   data_in, wen, ren : write data, write/push, read/pop
//   data_out          : registered read data
//   empty, full, almost_full, count : FIFO status (held idle in RAM mode)
//   overflow, underflow             : sticky rejected push / pop
module dpram_fifo_cfg
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned AFULL_THRESH = (2 ** ADDR_WIDTH) - 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_mode,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = count_width(ADDR_WIDTH);

  logic                  mode_q;
  logic                  mode_chg;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_d;
  logic                  empty_d, full_d, afull_d;
  logic                  ovf_d, unf_d;
  logic                  push_ok, pop_ok;
  logic                  mem_we, mem_re, bypass_en;
  logic [ADDR_WIDTH-1:0] mem_waddr, mem_raddr;

  assign mode_chg = (fifo_mode != mode_q);

  // Address mux, accept logic and next-state for pointers, count and sticky flags
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count;
    ovf_d     = overflow;
    unf_d     = underflow;
    push_ok   = 1'b0;
    pop_ok    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    bypass_en = 1'b0;
    mem_waddr = waddr;
    mem_raddr = raddr;

    if (mode_chg) begin
      // Reconfiguration cycle: clear FIFO state, ignore wen/ren, keep memory and data_out
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (fifo_mode == MODE_FIFO) begin
      // Pop sees only the registered empty flag, so a push into an empty FIFO never falls through
      pop_ok    = ren && !empty;
      push_ok   = wen && (!full || pop_ok);
      mem_we    = push_ok;
      mem_re    = pop_ok;
      mem_waddr = wptr_q;
      mem_raddr = rptr_q;
      if (push_ok) wptr_d = wptr_q + ADDR_WIDTH'(1);
      if (pop_ok)  rptr_d = rptr_q + ADDR_WIDTH'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count + CNT_W'(1);
        2'b01:   count_d = count - CNT_W'(1);
        default: count_d = count;
      endcase
      if (wen && !push_ok) ovf_d = 1'b1;
      if (ren && !pop_ok)  unf_d = 1'b1;
    end else begin
      mem_we    = wen;
      mem_re    = ren;
      bypass_en = 1'b1;
    end
  end

  // Flags follow the next count; in RAM mode count stays 0 so they sit at idle values
  always_comb begin
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
    afull_d = (count_d >= CNT_W'(AFULL_THRESH));
  end

  // State and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_RAM;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      mode_q      <= fifo_mode;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count       <= count_d;
      empty       <= empty_d;
      full        <= full_d;
      almost_full <= afull_d;
      overflow    <= ovf_d;
      underflow   <= unf_d;
    end
  end

  dpram_sdp_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (mem_we),
    .waddr     (mem_waddr),
    .wdata     (data_in),
    .re        (mem_re),
    .raddr     (mem_raddr),
    .bypass_en (bypass_en),
    .rdata     (data_out)
  );

endmodule

// File: tb/tb_dpram_fifo_cfg.sv
// Directed self-checking bench: a 512x8 RAM-mode instance and an 8-deep FIFO instance.
module tb_dpram_fifo_cfg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // RAM-mode instance, ADDR_WIDTH=9
  logic       r_mode, r_wen, r_ren;
  logic [8:0] r_waddr, r_raddr;
  logic [7:0] r_din, r_dout;
  logic       r_empty, r_full, r_af, r_ovf, r_unf;
  logic [9:0] r_count;

  // FIFO instance, ADDR_WIDTH=3, AFULL_THRESH=6
  logic       f_mode, f_wen, f_ren;
  logic [2:0] f_waddr, f_raddr;
  logic [7:0] f_din, f_dout;
  logic       f_empty, f_full, f_af, f_ovf, f_unf;
  logic [3:0] f_count;

  dpram_fifo_cfg #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) u_ram (
    .clk(clk), .rst_n(rst_n), .fifo_mode(r_mode), .waddr(r_waddr), .raddr(r_raddr),
    .data_in(r_din), .wen(r_wen), .ren(r_ren), .data_out(r_dout), .empty(r_empty),
    .full(r_full), .almost_full(r_af), .count(r_count), .overflow(r_ovf), .underflow(r_unf)
  );

  dpram_fifo_cfg #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AFULL_THRESH(6)) u_fifo (
    .clk(clk), .rst_n(rst_n), .fifo_mode(f_mode), .waddr(f_waddr), .raddr(f_raddr),
    .data_in(f_din), .wen(f_wen), .ren(f_ren), .data_out(f_dout), .empty(f_empty),
    .full(f_full), .almost_full(f_af), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference FIFO contents and expected sticky state
  logic [7:0] mq[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf  = 1'b0;
  logic       m_unf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected FIFO status from the reference queue and sticky bits
  task automatic chk_fifo(input string tag);
    chk({tag, ".count"}, 32'(f_count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(f_empty), 32'(mq.size() == 0));
    chk({tag, ".full"},  32'(f_full),  32'(mq.size() == 8));
    chk({tag, ".afull"}, 32'(f_af),    32'(mq.size() >= 6));
    chk({tag, ".dout"},  32'(f_dout),  32'(m_dout));
    chk({tag, ".ovf"},   32'(f_ovf),   32'(m_ovf));
    chk({tag, ".unf"},   32'(f_unf),   32'(m_unf));
  endtask

  // One FIFO cycle with optional push/pop; reference updated from its own occupancy
  task automatic fifo_op(input string tag, input logic push, input logic pop, input logic [7:0] din);
    logic p_ok, q_ok;
    f_wen = push;
    f_ren = pop;
    f_din = din;
    q_ok  = pop && (mq.size() > 0);
    p_ok  = push && ((mq.size() < 8) || q_ok);
    if (q_ok) m_dout = mq.pop_front();
    if (p_ok) mq.push_back(din);
    if (push && !p_ok) m_ovf = 1'b1;
    if (pop && !q_ok)  m_unf = 1'b1;
    step();
    f_wen = 1'b0;
    f_ren = 1'b0;
    chk_fifo(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    r_mode = 1'b0; r_wen = 1'b0; r_ren = 1'b0; r_waddr = '0; r_raddr = '0; r_din = '0;
    f_mode = 1'b0; f_wen = 1'b0; f_ren = 1'b0; f_waddr = '0; f_raddr = '0; f_din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_fifo("reset");
    chk("reset.ram_dout", 32'(r_dout), 32'h00);
    rst_n = 1'b1;
    step();

    // ---- RAM mode ----
    r_wen = 1'b1; r_waddr = 9'h1FF; r_din = 8'hA5;
    step();
    r_wen = 1'b0; r_ren = 1'b1; r_raddr = 9'h1FF;
    step();
    chk("ram.read", 32'(r_dout), 32'hA5);
    r_ren = 1'b0; r_raddr = 9'h000;
    step();
    step();
    chk("ram.hold", 32'(r_dout), 32'hA5);
    r_wen = 1'b1; r_waddr = 9'h010; r_din = 8'h00;
    step();
    r_ren = 1'b1; r_raddr = 9'h010; r_din = 8'h3C;
    step();
    r_wen = 1'b0; r_ren = 1'b0;
    chk("ram.wfirst", 32'(r_dout), 32'h3C);
    chk("ram.empty", 32'(r_empty), 32'h1);
    chk("ram.count", 32'(r_count), 32'h0);
    chk("ram.flags", 32'({r_full, r_af, r_ovf, r_unf}), 32'h0);

    // ---- FIFO fill / drain ----
    f_mode = 1'b1;
    step();
    chk_fifo("enter");
    for (int i = 1; i <= 8; i++) begin
      fifo_op("fill", 1'b1, 1'b0, 8'(i));
      chk("fill.af_edge", 32'(f_af), 32'(i >= 6));
    end
    chk("fill.full8", 32'(f_full), 32'h1);
    fifo_op("push9", 1'b1, 1'b0, 8'h09);
    chk("push9.ovf", 32'(f_ovf), 32'h1);
    chk("push9.count", 32'(f_count), 32'h8);
    for (int i = 1; i <= 8; i++) begin
      fifo_op("drain", 1'b0, 1'b1, 8'h00);
      chk("drain.order", 32'(f_dout), 32'(i));
    end
    chk("drain.empty", 32'(f_empty), 32'h1);
    fifo_op("pop9", 1'b0, 1'b1, 8'h00);
    chk("pop9.unf", 32'(f_unf), 32'h1);
    chk("pop9.dout", 32'(f_dout), 32'h08);

    // ---- wrap with simultaneous push/pop ----
    fifo_op("pre", 1'b1, 1'b0, 8'h50);
    fifo_op("pre", 1'b1, 1'b0, 8'h51);
    for (int i = 0; i < 20; i++) begin
      fifo_op("stream", 1'b1, 1'b1, 8'(8'h80 + i));
      chk("stream.count", 32'(f_count), 32'h2);
    end
    chk("stream.last", 32'(f_dout), 32'h91);
    for (int i = 0; i < 6; i++) fifo_op("refill", 1'b1, 1'b0, 8'(8'hC0 + i));
    fifo_op("pp_full", 1'b1, 1'b1, 8'hEE);
    chk("pp_full.count", 32'(f_count), 32'h8);
    chk("pp_full.dout", 32'(f_dout), 32'h92);
    for (int i = 0; i < 8; i++) fifo_op("drain2", 1'b0, 1'b1, 8'h00);
    chk("drain2.last", 32'(f_dout), 32'hEE);

    // ---- mode toggle clears FIFO state ----
    for (int i = 0; i < 5; i++) fifo_op("five", 1'b1, 1'b0, 8'(8'h60 + i));
    fifo_op("ovf_again", 1'b1, 1'b1, 8'h70);
    f_mode = 1'b0; f_wen = 1'b1; f_din = 8'hAB;
    step();
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    chk_fifo("to_ram");
    f_mode = 1'b1; f_wen = 1'b1;
    step();
    f_wen = 1'b0;
    chk_fifo("to_fifo");
    chk("to_fifo.count", 32'(f_count), 32'h0);

    // ---- push+pop while empty ----
    fifo_op("pp_empty", 1'b1, 1'b1, 8'h77);
    chk("pp_empty.count", 32'(f_count), 32'h1);
    chk("pp_empty.unf", 32'(f_unf), 32'h1);
    fifo_op("pop77", 1'b0, 1'b1, 8'h00);
    chk("pop77.dout", 32'(f_dout), 32'h77);

    // ---- asynchronous reset mid-operation ----
    for (int i = 0; i < 3; i++) fifo_op("three", 1'b1, 1'b0, 8'(8'h30 + i));
    chk("pre_rst.count", 32'(f_count), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete(); m_dout = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    chk_fifo("async_rst");
    chk("async_rst.ram_dout", 32'(r_dout), 32'h00);
    #2;
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
